// File: rtl/definitions_pkg.sv
// Shared pipeline definitions: data-memory access widths, access-unit states and the fault rule.
package definitions;

  // Bit 3 separates stores from loads so every RV32I width has a unique encoding.
  typedef enum logic [3:0] {
    LB  = 4'b0000,
    LH  = 4'b0001,
    LW  = 4'b0010,
    LBU = 4'b0100,
    LHU = 4'b0101,
    SB  = 4'b1000,
    SH  = 4'b1001,
    SW  = 4'b1010
  } memWidth_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmemState_t;

  // Unsigned-store encodings (1xx) have no RV32I meaning, so they fault like other illegal widths.
  function automatic logic access_fault(input logic rd, input logic wr,
                                        input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (rd && wr) begin
      bad = 1'b1;
    end else begin
      case (f3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = off[0];
        3'b010:  bad = (off != 2'b00);
        3'b100:  bad = wr;
        3'b101:  bad = wr | off[0];
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/dmem_access_unit_load_formatter.sv
// Combinational load lane select and sign/zero extension.
// Zero latency; no flow control, the caller registers the result.
module load_formatter
  import definitions::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {byte_off, 3'b000};

  always_comb begin
    data = shifted;
    case (memWidth_t'({1'b0, funct3}))
      LB:      data = {{24{shifted[7]}}, shifted[7:0]};
      LH:      data = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     data = {24'h0, shifted[7:0]};
      LHU:     data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: load/store to word-aligned req/ack bus, load formatting.
// Minimum 3 cycles per access (IDLE, REQ until dAck, DONE); pipeline stalled while IDLE-accepted and in REQ.
module dmem_access_unit
  import definitions::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  memRead_Mem_In,
  input  logic                  memWrite_Mem_In,
  input  logic [2:0]            funct3_Mem_In,
  input  logic [31:0]           addr_Mem_In,
  input  logic [31:0]           storeData_Mem_In,
  output logic [31:0]           readD_Mem_Out,
  output logic                  stall_Mem_Out,
  output logic                  fault_Mem_Out,
  output logic                  dReq,
  output logic                  dWe,
  output logic [ADDR_WIDTH-1:0] dAddr,
  output logic [31:0]           dWData,
  output logic [3:0]            dBe,
  input  logic                  dAck,
  input  logic [31:0]           dRData
);

  dmemState_t  state, state_next;
  logic        access, bad, accept;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        is_load_q;
  logic [31:0] load_data;

  assign access = memRead_Mem_In | memWrite_Mem_In;
  assign bad    = access_fault(memRead_Mem_In, memWrite_Mem_In, funct3_Mem_In, addr_Mem_In[1:0]);
  assign accept = (state == IDLE) && access && !bad;
  assign dReq   = (state == REQ);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = storeData_Mem_In;
    case (funct3_Mem_In[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr_Mem_In[1:0];
        wdata_next = {4{storeData_Mem_In[7:0]}};
      end
      2'b01: begin
        be_next    = addr_Mem_In[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{storeData_Mem_In[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next    = state;
    stall_Mem_Out = 1'b0;
    fault_Mem_Out = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (bad) begin
            fault_Mem_Out = 1'b1;
          end else begin
            stall_Mem_Out = 1'b1;
            state_next    = REQ;
          end
        end
      end
      REQ: begin
        stall_Mem_Out = 1'b1;
        if (dAck) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  load_formatter u_load_formatter (
    .rdata    (dRData),
    .funct3   (funct3_q),
    .byte_off (off_q),
    .data     (load_data)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= IDLE;
      readD_Mem_Out <= 32'h0;
      dWe           <= 1'b0;
      dAddr         <= '0;
      dWData        <= 32'h0;
      dBe           <= 4'h0;
      funct3_q      <= 3'b0;
      off_q         <= 2'b0;
      is_load_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        dWe       <= memWrite_Mem_In;
        dAddr     <= {addr_Mem_In[ADDR_WIDTH-1:2], 2'b00};
        dWData    <= wdata_next;
        dBe       <= be_next;
        funct3_q  <= funct3_Mem_In;
        off_q     <= addr_Mem_In[1:0];
        is_load_q <= memRead_Mem_In;
      end
      if ((state == REQ) && dAck) begin
        readD_Mem_Out <= is_load_q ? load_data : 32'h0;
      end
    end
  end

endmodule
